tensor_core_stream_loader: RTL and testbench
============================================

# tensor_core_stream_loader

Byte-stream front end and result drain for the 4x4 int8 tensor core. It collects 32 operand bytes (matrix A, then matrix B) over a valid/ready input stream into registered 128-bit operands. It drives those operands into the combinational tensor core and captures the core's 128-bit product once. It then returns the 16 result bytes over a valid/ready output stream and re-arms for the next pair.

## Interface
Parameters (fixed localparams, not overridable):
- DIM, 4, matrix dimension
- ELEM_W, 8, element width in bits

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- abort  input  1  synchronous, highest priority; returns the block to LOAD_A
- in_valid  input  1  input byte valid
- in_ready  output  1  block accepts an input byte
- in_data  input  8  operand byte
- out_valid  output  1  result byte valid
- out_ready  input  1  downstream accepts a result byte
- out_data  output  8  result byte
- out_last  output  1  marks result byte 15
- operand_a  output  128  matrix A to the tensor core's input1
- operand_b  output  128  matrix B to the tensor core's input2
- result_in  input  128  tensor core output
- busy  output  1  high in LOAD_B, CAPTURE and DRAIN

## Operation
- Packing (A, B and result): element (i,j) occupies bits [((3-i)*4+(3-j))*8 +: 8]. Element (0,0) sits at bits 127:120.
- Stream order is row-major, (0,0) first. Stream index n maps to i=n/4, j=n%4.
- States:
  - LOAD_A: in_ready=1.
  - LOAD_B: in_ready=1.
  - CAPTURE: in_ready=0, out_valid=0.
  - DRAIN: out_valid=1.
- The 4-bit index counter idx is shared by all states.
- LOAD_A: each handshake (in_valid & in_ready) writes in_data to A element idx, then idx++. The handshake at idx=15 sets idx to 0 and moves to LOAD_B.
- LOAD_B: same as LOAD_A, writing into B. The handshake at idx=15 moves to CAPTURE.
- CAPTURE: lasts exactly one cycle. result_reg <= result_in, then go to DRAIN with idx=0.
- DRAIN:
  - out_data = result_reg element idx; out_last = (idx==15).
  - Each handshake (out_valid & out_ready) does idx++.
  - The handshake with out_last goes to LOAD_A with idx=0.
- Arithmetic is done by the core: an 8-bit sum of 8-bit products, modulo 256. This block passes values through unmodified.
- Operand registers are never cleared except by reset. They hold their last values across LOAD_A/LOAD_B until overwritten element by element.
- in_valid is ignored outside LOAD_A/LOAD_B, and out_ready is ignored outside DRAIN.
- abort=1 on a clock edge, in any state:
  - state becomes LOAD_A, idx becomes 0.
  - operands and result_reg are retained.
  - Any handshake present in that cycle is dropped: no write, no index advance.
- busy = (state != LOAD_A).

## Timing
- Reset (rst_n low, asynchronous):
  - state=LOAD_A, idx=0, operand_a=0, operand_b=0, result_reg=0.
  - out_valid=0, out_data=0, out_last=0, busy=0.
  - in_ready=0 while rst_n is low; in_ready=1 from the first clock after release.
- in_ready, out_valid, out_data, out_last and busy are decoded from registered state, idx and result_reg only. There is no combinational path from in_valid or out_ready to any output.
- Best-case latency: the last B byte is accepted at edge T. CAPTURE occupies cycle T..T+1. out_valid=1 for byte 0 from edge T+1.
- Throughput: 1 byte/cycle in and out. A full transaction with no stalls is 32 + 1 + 16 = 49 cycles.
- Backpressure: out_data and out_last stay stable while out_valid=1 and out_ready=0. in_ready never drops mid-load except on abort or leaving the load state.
- operand_a/operand_b change only on load handshakes, so result_in is settled during CAPTURE.
- Back-to-back transactions: the edge carrying the out_last handshake enters LOAD_A, and in_ready=1 on the next cycle.

## Test plan
- A=identity (bytes 1,0,0,0,0,1,…), B=bytes 1..16 with in_valid held high -> out_data 1..16 in order, out_last on 16, first out_valid exactly 1 cycle after the last B accept.
- A all 0x02, B all 0x03 -> 16 result bytes of 0x18. Check operand_a=0x0202…02 and operand_b=0x0303…03.
- A all 0x08, B all 0x09 -> every byte 0x20 (288 mod 256), checking wrap-around.
- Random A/B with in_valid and out_ready randomly deasserted (~50%) -> results match a 4x4 mod-256 matmul model, and out_data is stable whenever out_valid & !out_ready.
- abort asserted after 5 B bytes, then a full fresh A/B load of all 0x01 -> no output during the aborted sequence; the new run outputs sixteen 0x04 bytes.
- rst_n pulsed low during DRAIN at idx=7 -> out_valid=0, operands=0, busy=0 immediately. The next full load (A=B=identity) outputs identity bytes.

Source files
------------

// File: rtl/tensor_core_stream_loader.sv
// rtl/tensor_core_stream_loader.sv - byte-stream operand loader and result drain for the 4x4 int8 tensor core
module tensor_core_stream_loader (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         abort,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_data,
    output logic         out_last,
    output logic [127:0] operand_a,
    output logic [127:0] operand_b,
    input  logic [127:0] result_in,
    output logic         busy
);

    localparam int DIM      = 4;
    localparam int ELEM_W   = 8;
    localparam int NELEM    = DIM * DIM;
    localparam int MAT_W    = NELEM * ELEM_W;
    localparam int IDX_W    = $clog2(NELEM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NELEM - 1);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [MAT_W-1:0]   a_q, a_d;
    logic [MAT_W-1:0]   b_q, b_d;
    logic [MAT_W-1:0]   res_q, res_d;
    logic               arm_q;

    logic               in_hs;
    logic               out_hs;
    logic [6:0]         lane_lsb;

    // Stream index n lands at bits (15-n)*8, and 15-n is just ~n on 4 bits.
    assign lane_lsb = {~idx_q, 3'b000};

    // arm_q holds in_ready low only while reset is asserted.
    assign in_ready  = arm_q && ((state_q == LOAD_A) || (state_q == LOAD_B));
    assign out_valid = (state_q == DRAIN);
    assign out_data  = out_valid ? res_q[lane_lsb +: ELEM_W] : '0;
    assign out_last  = out_valid && (idx_q == LAST_IDX);
    assign busy      = (state_q != LOAD_A);
    assign operand_a = a_q;
    assign operand_b = b_q;

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        if (abort) begin
            state_d = LOAD_A;
            idx_d   = '0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (in_hs) begin
                        a_d[lane_lsb +: ELEM_W] = in_data;
                        idx_d = idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = LOAD_B;
                        end
                    end
                end
                LOAD_B: begin
                    if (in_hs) begin
                        b_d[lane_lsb +: ELEM_W] = in_data;
                        idx_d = idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    res_d   = result_in;
                    idx_d   = '0;
                    state_d = DRAIN;
                end
                DRAIN: begin
                    if (out_hs) begin
                        idx_d = idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = LOAD_A;
                            idx_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = LOAD_A;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            arm_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tensor_core_stream_loader.sv
// tb/tb_tensor_core_stream_loader.sv - randomized self-checking bench for tensor_core_stream_loader
module tb_tensor_core_stream_loader;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         abort = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = 8'h00;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [7:0]   out_data;
    logic         out_last;
    logic [127:0] operand_a;
    logic [127:0] operand_b;
    logic [127:0] result_in;
    logic         busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] ma [16];
    logic [7:0] mb [16];
    logic [7:0] prev_b [16];

    tensor_core_stream_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .result_in (result_in),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the combinational tensor core.
    function automatic logic [127:0] core_mac(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] r;
        logic [7:0]   s;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    s = s + 8'(a[((3 - i) * 4 + (3 - k)) * 8 +: 8] * b[((3 - k) * 4 + (3 - j)) * 8 +: 8]);
                end
                r[((3 - i) * 4 + (3 - j)) * 8 +: 8] = s;
            end
        end
        return r;
    endfunction

    assign result_in = core_mac(operand_a, operand_b);

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int n);
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            s = s + int'(ma[(n / 4) * 4 + k]) * int'(mb[k * 4 + (n % 4)]);
        end
        return 8'(s % 256);
    endfunction

    function automatic logic [127:0] pack(input logic [7:0] m [16]);
        logic [127:0] p;
        p = '0;
        for (int n = 0; n < 16; n++) begin
            p[(15 - n) * 8 +: 8] = m[n];
        end
        return p;
    endfunction

    task automatic send_byte(input logic [7:0] d, input int stall_pct);
        int t;
        t = 0;
        while (int'($urandom_range(99)) < stall_pct) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check_eq("in_ready_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load_matrices(input int stall_pct);
        for (int n = 0; n < 16; n++) send_byte(ma[n], stall_pct);
        for (int n = 0; n < 16; n++) send_byte(mb[n], stall_pct);
    endtask

    task automatic drain(input int count, input int stall_pct);
        int t;
        logic [7:0] d;
        logic l;
        for (int n = 0; n < count; n++) begin
            t = 0;
            while (!out_valid && t < 200) begin
                @(negedge clk);
                t++;
            end
            check_eq("out_valid_wait", out_valid, 1);
            while (int'($urandom_range(99)) < stall_pct) begin
                d = out_data;
                l = out_last;
                out_ready = 1'b0;
                @(negedge clk);
                check_eq("stall_data_stable", out_data, d);
                check_eq("stall_last_stable", out_last, l);
            end
            out_ready = 1'b1;
            check_eq("out_data", out_data, exp_byte(n));
            check_eq("out_last", out_last, (n == 15));
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic run_txn(input int stall_in, input int stall_out, input bit check_lat);
        load_matrices(stall_in);
        check_eq("operand_a", operand_a, pack(ma));
        check_eq("operand_b", operand_b, pack(mb));
        if (check_lat) begin
            check_eq("capture_no_valid", out_valid, 0);
            check_eq("capture_busy", busy, 1);
            @(negedge clk);
            check_eq("first_valid_latency", out_valid, 1);
        end
        drain(16, stall_out);
        check_eq("rearm_busy", busy, 0);
        check_eq("rearm_in_ready", in_ready, 1);
    endtask

    initial begin
        #12;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_last", out_last, 0);
        check_eq("rst_operand_a", operand_a, 0);
        check_eq("rst_operand_b", operand_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("release_in_ready_low", in_ready, 0);
        @(negedge clk);
        check_eq("release_in_ready_high", in_ready, 1);

        for (int n = 0; n < 16; n++) begin
            ma[n] = (n / 4 == n % 4) ? 8'd1 : 8'd0;
            mb[n] = 8'(n + 1);
        end
        run_txn(0, 0, 1);

        for (int n = 0; n < 16; n++) begin
            ma[n] = 8'h02;
            mb[n] = 8'h03;
        end
        run_txn(0, 0, 1);
        check_eq("const_a_02", operand_a, {16{8'h02}});
        check_eq("const_b_03", operand_b, {16{8'h03}});
        check_eq("model_0x18", exp_byte(0), 8'h18);

        for (int n = 0; n < 16; n++) begin
            ma[n] = 8'h08;
            mb[n] = 8'h09;
        end
        check_eq("model_wrap", exp_byte(5), 8'h20);
        run_txn(0, 0, 1);

        for (int r = 0; r < 6; r++) begin
            for (int n = 0; n < 16; n++) begin
                ma[n] = 8'($urandom);
                mb[n] = 8'($urandom);
            end
            run_txn(50, 50, 0);
        end

        prev_b = mb;
        for (int n = 0; n < 16; n++) ma[n] = 8'h01;
        for (int n = 0; n < 16; n++) send_byte(8'h01, 0);
        for (int n = 0; n < 5; n++) begin
            send_byte(8'h01, 0);
            check_eq("abort_seq_no_valid", out_valid, 0);
        end
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_out_valid", out_valid, 0);
        check_eq("abort_in_ready", in_ready, 1);
        for (int n = 0; n < 5; n++) prev_b[n] = 8'h01;
        check_eq("abort_operand_b_kept", operand_b, pack(prev_b));
        check_eq("abort_operand_a_kept", operand_a, {16{8'h01}});
        for (int n = 0; n < 16; n++) mb[n] = 8'h01;
        check_eq("model_0x04", exp_byte(9), 8'h04);
        run_txn(0, 0, 1);

        for (int n = 0; n < 16; n++) begin
            ma[n] = 8'($urandom);
            mb[n] = 8'($urandom);
        end
        load_matrices(0);
        drain(7, 0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_out_data", out_data, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_in_ready", in_ready, 0);
        check_eq("midrst_operand_a", operand_a, 0);
        check_eq("midrst_operand_b", operand_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 16; n++) begin
            ma[n] = (n / 4 == n % 4) ? 8'd1 : 8'd0;
            mb[n] = ma[n];
        end
        run_txn(0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
